// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int unsigned DIV_DIVIDEND_W = 5;
  localparam int unsigned DIV_DIVISOR_W  = 3;

  // Width of the iteration counter; never collapses to zero bits
  function automatic int unsigned div_cnt_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned DIV_CNT_W = div_cnt_w(DIV_DIVIDEND_W);

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits.
module div_restore_step #(
  parameter int unsigned DIVISOR_W = 3
) (
  input  logic [DIVISOR_W:0]   rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   rem_o,
  output logic                 q_o
);

  localparam int unsigned RW = DIVISOR_W + 1;
  localparam int unsigned EW = DIVISOR_W + 2;

  logic [EW-1:0] shifted_c;
  logic [RW-1:0] diff_c;

  // Shift/compare/subtract at one extra bit so the full remainder feeds in
  always_comb begin
    shifted_c = {rem_i, bit_i};
    q_o       = (shifted_c >= EW'(divisor_i));
    diff_c    = RW'(shifted_c - EW'(divisor_i));
    rem_o     = q_o ? diff_c : shifted_c[RW-1:0];
  end

endmodule

// File: rtl/div_3_bit_seq.sv
// Iterative restoring divider with start/busy/done handshake, one quotient
// bit per clock. Optional result self-check enabled by DIV_SELF_CHECK_EN.
module div_3_bit_seq
  import div_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = DIV_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
`ifdef DIV_SELF_CHECK_EN
  output logic                  check_err,
`endif
  output logic                  dbz
);

  localparam int unsigned CNT_W = div_cnt_w(DIVIDEND_W);
  localparam int unsigned PW    = DIVIDEND_W + DIVISOR_W;

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [DIVIDEND_W-1:0] qacc_q, qacc_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  remo_q, remo_d;
  logic                  dbz_q, dbz_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef DIV_SELF_CHECK_EN
  logic                  check_err_q, check_err_d;
  logic [PW-1:0]         recon_c;
`endif

  logic [DIVISOR_W:0]    step_rem_c;
  logic                  step_q_c;

  // Single restoring step on the bit selected by the iteration counter
  div_restore_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[cnt_q]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem_c),
    .q_o       (step_q_c)
  );

  // Next-state, datapath and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qacc_d  = qacc_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef DIV_SELF_CHECK_EN
    check_err_d = check_err_q;
    recon_c     = PW'(quo_q) * PW'(dvs_q) + PW'(remo_q);
`endif

    unique case (state_q)
      RUN: begin
        busy_d = 1'b1;
        rem_d  = step_rem_c;
        qacc_d = {qacc_q[DIVIDEND_W-2:0], step_q_c};
        if (cnt_q == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quo_d   = {qacc_q[DIVIDEND_W-2:0], step_q_c};
          remo_d  = step_rem_c[DIVISOR_W-1:0];
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        // IDLE and DONE both accept a new request
        state_d = IDLE;
`ifdef DIV_SELF_CHECK_EN
        if (state_q == DONE) begin
          check_err_d = !dbz_q && ((recon_c != PW'(dvd_q)) || (remo_q >= dvs_q));
        end
`endif
        if (start) begin
          if (divisor != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
            dvd_d   = dividend;
            dvs_d   = divisor;
            rem_d   = '0;
            qacc_d  = '0;
            cnt_d   = CNT_W'(DIVIDEND_W - 1);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            quo_d   = '1;
            remo_d  = '0;
            dbz_d   = 1'b1;
          end
        end
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qacc_q  <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_SELF_CHECK_EN
      check_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qacc_q  <= qacc_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DIV_SELF_CHECK_EN
      check_err_q <= check_err_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = remo_q;
  assign dbz       = dbz_q;
`ifdef DIV_SELF_CHECK_EN
  assign check_err = check_err_q;
`endif

endmodule
